// File: rtl/ct_ifu_predecd_array_arb.sv
// Predecode array port arbiter: refill writes, fetch reads and a full-array invalidate sweep.
// Optional macro PREDECD_FETCH_STARVE_GUARD_EN: fetch wins after three refill wins under contention.
module ct_ifu_predecd_array_arb #(
    parameter int ROWS = 1024
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        fetch_req,
    input  logic [15:0] fetch_index,
    output logic        fetch_grant,
    output logic        fetch_dout_vld,
    output logic [31:0] fetch_dout,
    input  logic        refill_req,
    input  logic [15:0] refill_index,
    input  logic [31:0] refill_din,
    output logic        refill_grant,
    input  logic        inv_start,
    output logic        inv_busy,
    output logic        inv_done,
    output logic [15:0] ifu_icache_index,
    output logic        ifu_icache_predecd_array0_cen_b,
    output logic        ifu_icache_predecd_array0_wen_b,
    output logic [31:0] ifu_icache_predecd_array0_din,
    output logic        ifu_icache_predecd_array0_clk_en,
    input  logic [31:0] icache_ifu_predecd_array0_dout
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} inv_state_e;

    localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);

    inv_state_e state_q, state_d;
    logic [9:0] row_cnt_q, row_cnt_d;
    logic       fetch_dout_vld_q, fetch_dout_vld_d;
    logic       idle;
    logic       starve_force;

    // Reset gates the grants so nothing is issued while cpurst_b is held low.
    assign idle = (state_q == IDLE) && cpurst_b;

`ifdef PREDECD_FETCH_STARVE_GUARD_EN
    logic [1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == 2'd3);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!(refill_req && fetch_req))
            starve_cnt_d = 2'd0;
        else if (fetch_grant)
            starve_cnt_d = 2'd0;
        else if (refill_grant)
            starve_cnt_d = starve_cnt_q + 2'd1;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) starve_cnt_q <= 2'd0;
        else           starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_force = 1'b0;
`endif

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q          <= IDLE;
            row_cnt_q        <= 10'd0;
            fetch_dout_vld_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            row_cnt_q        <= row_cnt_d;
            fetch_dout_vld_q <= fetch_dout_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            IDLE: begin
                row_cnt_d = 10'd0;
                if (inv_start) state_d = SWEEP;
            end
            SWEEP: begin
                row_cnt_d = row_cnt_q + 10'd1;
                if (row_cnt_q == LAST_ROW) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inv_busy     = (state_q == SWEEP) || (state_q == DONE);
        inv_done     = (state_q == DONE);
        refill_grant = idle && refill_req && !(starve_force && fetch_req);
        fetch_grant  = idle && fetch_req && (!refill_req || starve_force);

        fetch_dout_vld_d = fetch_grant;
        fetch_dout_vld   = fetch_dout_vld_q;
        fetch_dout       = fetch_dout_vld_q ? icache_ifu_predecd_array0_dout : 32'd0;

        ifu_icache_index                = 16'd0;
        ifu_icache_predecd_array0_cen_b = 1'b1;
        ifu_icache_predecd_array0_wen_b = 1'b1;
        ifu_icache_predecd_array0_din   = 32'd0;
        if (state_q == SWEEP) begin
            ifu_icache_index                = {3'b000, row_cnt_q, 3'b000};
            ifu_icache_predecd_array0_cen_b = 1'b0;
            ifu_icache_predecd_array0_wen_b = 1'b0;
        end else if (refill_grant) begin
            ifu_icache_index                = refill_index;
            ifu_icache_predecd_array0_cen_b = 1'b0;
            ifu_icache_predecd_array0_wen_b = 1'b0;
            ifu_icache_predecd_array0_din   = refill_din;
        end else if (fetch_grant) begin
            ifu_icache_index                = fetch_index;
            ifu_icache_predecd_array0_cen_b = 1'b0;
        end
        // Keep the array clock running for the read-data return cycle too.
        ifu_icache_predecd_array0_clk_en = !ifu_icache_predecd_array0_cen_b || fetch_dout_vld_q;
    end

endmodule

// File: tb/tb_ct_ifu_predecd_array_arb.sv
// Scoreboard bench for ct_ifu_predecd_array_arb: a cycle-level reference model pushes expected
// outputs, a negedge monitor pops and compares. A behavioural SRAM answers array reads.
module tb_ct_ifu_predecd_array_arb;
    localparam int ROWS = 1024;
`ifdef PREDECD_FETCH_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0, refill_req = 1'b0, inv_start = 1'b0;
    logic [15:0] fetch_index = '0, refill_index = '0;
    logic [31:0] refill_din = '0, array_dout = '0;
    logic        fetch_grant, fetch_dout_vld, refill_grant, inv_busy, inv_done;
    logic [31:0] fetch_dout, arr_din;
    logic [15:0] arr_index;
    logic        arr_cen_b, arr_wen_b, arr_clk_en;

    always #5 clk = ~clk;

    ct_ifu_predecd_array_arb #(.ROWS(ROWS)) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .fetch_req(fetch_req), .fetch_index(fetch_index), .fetch_grant(fetch_grant),
        .fetch_dout_vld(fetch_dout_vld), .fetch_dout(fetch_dout),
        .refill_req(refill_req), .refill_index(refill_index), .refill_din(refill_din),
        .refill_grant(refill_grant), .inv_start(inv_start), .inv_busy(inv_busy), .inv_done(inv_done),
        .ifu_icache_index(arr_index), .ifu_icache_predecd_array0_cen_b(arr_cen_b),
        .ifu_icache_predecd_array0_wen_b(arr_wen_b), .ifu_icache_predecd_array0_din(arr_din),
        .ifu_icache_predecd_array0_clk_en(arr_clk_en), .icache_ifu_predecd_array0_dout(array_dout)
    );

    function automatic logic [31:0] init_val(logic [15:0] idx);
        return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Environment SRAM driven by the DUT's array port.
    logic [31:0] sram [int];
    always @(posedge clk) begin
        if (!arr_cen_b && !arr_wen_b) sram[int'(arr_index)] = arr_din;
        else if (!arr_cen_b) array_dout <= sram.exists(int'(arr_index)) ? sram[int'(arr_index)] : init_val(arr_index);
    end

    typedef struct {
        logic rg, fg, cen, wen, vld, busy, done;
        logic [15:0] idx;
        logic [31:0] din, dout;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [31:0] mem [int];
    int   sw_row = -1;
    bit   done_ph = 0;
    int   cnt = 0;
    bit   pend = 0;
    logic [31:0] pend_data = '0;

    int checks = 0, errors = 0;

    function automatic logic [31:0] mem_rd(logic [15:0] idx);
        return mem.exists(int'(idx)) ? mem[int'(idx)] : init_val(idx);
    endfunction

    task automatic step(input bit rst, input bit fr, input logic [15:0] fi, input bit rr,
                        input logic [15:0] ri, input logic [31:0] rd, input bit is);
        exp_t e;
        bit force_f;
        @(posedge clk);
        #1;
        rst_n = rst; fetch_req = fr; fetch_index = fi; refill_req = rr;
        refill_index = ri; refill_din = rd; inv_start = is;
        e = '{rg:0, fg:0, cen:1, wen:1, vld:0, busy:0, done:0, idx:16'h0, din:32'h0, dout:32'h0};
        if (!rst) begin
            sw_row = -1; done_ph = 0; cnt = 0; pend = 0;
        end else begin
            e.vld  = pend;
            e.dout = pend ? pend_data : 32'h0;
            e.busy = (sw_row >= 0) || done_ph;
            e.done = done_ph;
            pend = 0;
            if (sw_row >= 0) begin
                e.cen = 0; e.wen = 0; e.idx = 16'(sw_row * 8);
                mem[sw_row * 8] = 32'h0;
                if (sw_row == ROWS - 1) begin sw_row = -1; done_ph = 1; end
                else sw_row++;
            end else if (done_ph) begin
                done_ph = 0;
            end else begin
                force_f = GUARD && (cnt == 3);
                e.rg = rr && !(force_f && fr);
                e.fg = fr && (!rr || force_f);
                if (e.rg) begin
                    e.cen = 0; e.wen = 0; e.idx = ri; e.din = rd;
                    mem[int'(ri)] = rd;
                end else if (e.fg) begin
                    e.cen = 0; e.idx = fi;
                    pend = 1; pend_data = mem_rd(fi);
                end
                if (rr && fr) begin
                    if (e.fg) cnt = 0;
                    else if (e.rg) cnt++;
                end
                if (is) sw_row = 0;
            end
            if (!(rr && fr)) cnt = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("refill_grant", 32'(refill_grant), 32'(e.rg));
                chk("fetch_grant", 32'(fetch_grant), 32'(e.fg));
                chk("cen_b", 32'(arr_cen_b), 32'(e.cen));
                chk("wen_b", 32'(arr_wen_b), 32'(e.wen));
                chk("index", 32'(arr_index), 32'(e.idx));
                chk("din", arr_din, e.din);
                chk("fetch_dout_vld", 32'(fetch_dout_vld), 32'(e.vld));
                chk("fetch_dout", fetch_dout, e.dout);
                chk("inv_busy", 32'(inv_busy), 32'(e.busy));
                chk("inv_done", 32'(inv_done), 32'(e.done));
                if (!e.cen) chk("clk_en", 32'(arr_clk_en), 32'd1);
            end
        end
    end

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 0, 16'h0, 32'h0, 0);
    endtask

    task automatic busy_rand(input int n);
        for (int i = 0; i < n; i++)
            step(1, 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), $urandom, 1'($urandom));
    endtask

    initial begin : stim
        step(0, 1, 16'h0040, 1, 16'h0100, 32'h1, 0);
        step(0, 0, 16'h0, 0, 16'h0, 32'h0, 0);
        idle_n(2);
        // Fetch alone, then refill alone, then read back the refilled word.
        step(1, 1, 16'h0040, 0, 16'h0, 32'h0, 0);
        idle_n(1);
        step(1, 0, 16'h0, 1, 16'h0100, 32'hA5A5A5A5, 0);
        step(1, 1, 16'h0100, 0, 16'h0, 32'h0, 0);
        idle_n(2);
        // Full sweep with requests hammering throughout.
        step(1, 0, 16'h0, 0, 16'h0, 32'h0, 1);
        busy_rand(ROWS + 1);
        step(1, 1, 16'h0100, 0, 16'h0, 32'h0, 0);
        idle_n(2);
        // Continuous contention for 8 cycles.
        for (int i = 0; i < 8; i++) step(1, 1, 16'(i * 8), 1, 16'(16'h0200 + i * 8), $urandom, 0);
        idle_n(2);
        // Reset cut at sweep row 500.
        step(1, 0, 16'h0, 1, 16'h0300, 32'h33, 1);
        busy_rand(500);
        step(0, 1, 16'h0040, 1, 16'h0100, 32'h0, 1);
        step(0, 1, 16'h0040, 1, 16'h0100, 32'h0, 0);
        idle_n(4);
        step(1, 1, 16'h0008, 0, 16'h0, 32'h0, 0);
        idle_n(2);
        // Random traffic with occasional sweeps and resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 299) != 0), 1'($urandom), 16'($urandom_range(0, 63) * 8),
                 1'($urandom), 16'($urandom_range(0, 63) * 8), $urandom, ($urandom_range(0, 199) == 0));
        idle_n(3);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
